// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared constants and types for the RAM port arbiter slice.
//   MEM_AW / MEM_DW : default word-address and data widths
//   arbState_e      : 2-bit arbiter FSM encoding (IDLE / ACCESS / DONE)
//   CONFLICT_MAX    : saturation value of the 16-bit conflict counter
//   satInc()        : saturating increment used by the conflict counter
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int MEM_AW = 10;
    localparam int MEM_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arbState_e;

    localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

    // The counter sticks at its maximum instead of wrapping back to zero.
    function automatic logic [15:0] satInc(input logic [15:0] value);
        return (value == CONFLICT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin selector, purely combinational.
//   req0_i, req1_i : request lines of requester 0 and requester 1
//   lastGrant_i    : requester that won the previous arbitration
//   owner_o        : selected requester (only meaningful if a req is high)
//   conflict_o     : both requesters are asking in this cycle
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic lastGrant_i,
    output logic owner_o,
    output logic conflict_o
);

    // On a conflict the requester that did not win last time gets the port,
    // which makes continuous contention alternate 0,1,0,1.
    always_comb begin
        conflict_o = req0_i & req1_i;
        if (req0_i & req1_i) begin
            owner_o = ~lastGrant_i;
        end else if (req1_i) begin
            owner_o = 1'b1;
        end else begin
            owner_o = 1'b0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port synchronous RAM between two requesters
// (r0 = CPU data path, r1 = loader/DMA). Each access takes three cycles:
// IDLE (arbitrate + capture) -> ACCESS (drive RAM) -> DONE (ack + rdata).
// Ports:
//   clk, rst                        : clock and async active-high reset
//   rN_req/addr/we/wdata            : requester N access request
//   rN_ack/rdata                    : requester N completion pulse + data
//   ram_addr/wea/dina, ram_douta    : RAM port, douta valid one cycle later
//   busy                            : FSM not in IDLE
//   conflict_cnt                    : saturating count of contended IDLEs
// ---------------------------------------------------------------------------
module ram_port_arbiter
    import mem_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            r0_req,
    input  logic [AW-1:0]   r0_addr,
    input  logic [DW/8-1:0] r0_we,
    input  logic [DW-1:0]   r0_wdata,
    input  logic            r1_req,
    input  logic [AW-1:0]   r1_addr,
    input  logic [DW/8-1:0] r1_we,
    input  logic [DW-1:0]   r1_wdata,
    output logic            r0_ack,
    output logic [DW-1:0]   r0_rdata,
    output logic            r1_ack,
    output logic [DW-1:0]   r1_rdata,
    output logic [AW-1:0]   ram_addr,
    output logic [DW/8-1:0] ram_wea,
    output logic [DW-1:0]   ram_dina,
    input  logic [DW-1:0]   ram_douta,
    output logic            busy,
    output logic [15:0]     conflict_cnt
);

    localparam int BW = DW / 8;

    arbState_e         state_q, state_d;
    logic              owner_q, owner_d;
    logic              lastGrant_q, lastGrant_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [BW-1:0]     we_q, we_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [15:0]       conflictCnt_q, conflictCnt_d;

    logic              anyReq;
    logic              startAccess;
    logic              arbOwner;
    logic              arbConflict;

    assign anyReq      = r0_req | r1_req;
    assign startAccess = (state_q == IDLE) && anyReq;

    rr_arb2 u_rr_arb2 (
        .req0_i      (r0_req),
        .req1_i      (r1_req),
        .lastGrant_i (lastGrant_q),
        .owner_o     (arbOwner),
        .conflict_o  (arbConflict)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: only IDLE waits, the access itself is fixed-length.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (anyReq) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the winner's request on the IDLE->ACCESS edge so the access
    // in flight is immune to later input changes. Last-grant and the
    // conflict counter also move only on that edge.
    always_comb begin
        owner_d       = owner_q;
        lastGrant_d   = lastGrant_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        conflictCnt_d = conflictCnt_q;
        if (startAccess) begin
            owner_d     = arbOwner;
            lastGrant_d = arbOwner;
            addr_d      = arbOwner ? r1_addr  : r0_addr;
            we_d        = arbOwner ? r1_we    : r0_we;
            wdata_d     = arbOwner ? r1_wdata : r0_wdata;
            if (arbConflict) begin
                conflictCnt_d = satInc(conflictCnt_q);
            end
        end
    end

    // Request/bookkeeping registers. Last-grant resets to 1 so that
    // requester 0 wins the first conflict after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q       <= 1'b0;
            lastGrant_q   <= 1'b1;
            addr_q        <= '0;
            we_q          <= '0;
            wdata_q       <= '0;
            conflictCnt_q <= '0;
        end else begin
            owner_q       <= owner_d;
            lastGrant_q   <= lastGrant_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            conflictCnt_q <= conflictCnt_d;
        end
    end

    // FSM outputs are decoded from registered state only, so there is no
    // path from req to the RAM pins, and an async reset that drops the
    // state to IDLE kills ram_wea immediately.
    always_comb begin
        busy     = (state_q != IDLE);
        ram_addr = '0;
        ram_wea  = '0;
        ram_dina = '0;
        r0_ack   = 1'b0;
        r1_ack   = 1'b0;
        r0_rdata = '0;
        r1_rdata = '0;
        case (state_q)
            ACCESS: begin
                ram_addr = addr_q;
                ram_wea  = we_q;
                ram_dina = wdata_q;
            end
            DONE: begin
                if (owner_q) begin
                    r1_ack   = 1'b1;
                    r1_rdata = ram_douta;
                end else begin
                    r0_ack   = 1'b1;
                    r0_rdata = ram_douta;
                end
            end
            default: begin
            end
        endcase
    end

    assign conflict_cnt = conflictCnt_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
// Self-checking bench for ram_port_arbiter: table of single transactions
// with hand-computed results, followed by hand-written sequences for the
// multi-cycle cases (late req, contention, reset abort, saturation).
// A small byte-enabled synchronous RAM lives in the bench.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r1_req;
    logic [9:0]  r0_addr, r1_addr;
    logic [3:0]  r0_we, r1_we;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_ack, r1_ack;
    logic [31:0] r0_rdata, r1_rdata;
    logic [9:0]  ram_addr;
    logic [3:0]  ram_wea;
    logic [31:0] ram_dina;
    logic [31:0] ram_douta;
    logic        busy;
    logic [15:0] conflict_cnt;

    logic        loadMem;
    logic [31:0] mem [0:1023];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        r0Req;
        logic [9:0]  r0Addr;
        logic [3:0]  r0We;
        logic [31:0] r0Wdata;
        logic        r1Req;
        logic [9:0]  r1Addr;
        logic [3:0]  r1We;
        logic [31:0] r1Wdata;
        logic        expAck0;
        logic        expAck1;
        logic [9:0]  expAddr;
        logic [3:0]  expWe;
        logic [31:0] expDina;
        logic        checkRdata;
        logic [31:0] expRdata;
        logic [15:0] expConflict;
    } vec_t;

    vec_t vecs [10];

    ram_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .r0_req       (r0_req),
        .r0_addr      (r0_addr),
        .r0_we        (r0_we),
        .r0_wdata     (r0_wdata),
        .r1_req       (r1_req),
        .r1_addr      (r1_addr),
        .r1_we        (r1_we),
        .r1_wdata     (r1_wdata),
        .r0_ack       (r0_ack),
        .r0_rdata     (r0_rdata),
        .r1_ack       (r1_ack),
        .r1_rdata     (r1_rdata),
        .ram_addr     (ram_addr),
        .ram_wea      (ram_wea),
        .ram_dina     (ram_dina),
        .ram_douta    (ram_douta),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Bench RAM: read-first synchronous single port with byte enables.
    // While loadMem is high it is preloaded with the known test contents.
    always @(posedge clk) begin
        if (loadMem) begin
            mem[10'h010] <= 32'hDEADBEEF;
            mem[10'h020] <= 32'h55667788;
            mem[10'h3FF] <= 32'hAABBCCDD;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wea[b]) mem[ram_addr][8*b +: 8] <= ram_dina[8*b +: 8];
            end
            ram_douta <= mem[ram_addr];
        end
    end

    // One comparison: counts it, and reports it if the values differ.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        r0_req = 1'b0; r0_addr = '0; r0_we = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_addr = '0; r1_we = '0; r1_wdata = '0;
    endtask

    // Runs one transaction starting from IDLE at a negedge; ends at the
    // negedge of the following IDLE cycle. Inputs are scrambled during
    // ACCESS so that anything not taken from the captured copy shows up.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        r0_req = v.r0Req; r0_addr = v.r0Addr; r0_we = v.r0We; r0_wdata = v.r0Wdata;
        r1_req = v.r1Req; r1_addr = v.r1Addr; r1_we = v.r1We; r1_wdata = v.r1Wdata;
        @(posedge clk);
        @(negedge clk);
        r0_req = 1'b0; r0_addr = ~v.r0Addr; r0_we = ~v.r0We; r0_wdata = ~v.r0Wdata;
        r1_req = 1'b0; r1_addr = ~v.r1Addr; r1_we = ~v.r1We; r1_wdata = ~v.r1Wdata;
        #1;
        checkOutput({tag, " access busy"}, 32'(busy), 32'd1);
        checkOutput({tag, " ram_addr"}, 32'(ram_addr), 32'(v.expAddr));
        checkOutput({tag, " ram_wea"}, 32'(ram_wea), 32'(v.expWe));
        checkOutput({tag, " ram_dina"}, ram_dina, v.expDina);
        checkOutput({tag, " early ack"}, {r0_ack, r1_ack}, 32'd0);
        @(negedge clk);
        checkOutput({tag, " r0_ack"}, 32'(r0_ack), 32'(v.expAck0));
        checkOutput({tag, " r1_ack"}, 32'(r1_ack), 32'(v.expAck1));
        checkOutput({tag, " done wea"}, 32'(ram_wea), 32'd0);
        checkOutput({tag, " conflict_cnt"}, 32'(conflict_cnt), 32'(v.expConflict));
        if (v.checkRdata) begin
            checkOutput({tag, " rdata"}, v.expAck0 ? r0_rdata : r1_rdata, v.expRdata);
        end
        @(negedge clk);
        checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " idle acks"}, {r0_ack, r1_ack}, 32'd0);
        clearInputs();
    endtask

    // Main sequence.
    initial begin
        vec_t v;
        // r0Req addr we wdata | r1Req addr we wdata | ack0 ack1 addr wea dina | chk rdata | conflict
        vecs[0] = '{1'b1, 10'h010, 4'h0, 32'h0,      1'b0, 10'h000, 4'h0, 32'h0,
                    1'b1, 1'b0, 10'h010, 4'h0, 32'h0,      1'b1, 32'hDEADBEEF, 16'd0};
        vecs[1] = '{1'b0, 10'h000, 4'h0, 32'h0,      1'b1, 10'h3FF, 4'b0100, 32'h11223344,
                    1'b0, 1'b1, 10'h3FF, 4'b0100, 32'h11223344, 1'b0, 32'h0, 16'd0};
        vecs[2] = '{1'b0, 10'h000, 4'h0, 32'h0,      1'b1, 10'h3FF, 4'h0, 32'h0,
                    1'b0, 1'b1, 10'h3FF, 4'h0, 32'h0,      1'b1, 32'hAA22CCDD, 16'd0};
        vecs[3] = '{1'b1, 10'h020, 4'h0, 32'h0,      1'b1, 10'h010, 4'h0, 32'h0,
                    1'b1, 1'b0, 10'h020, 4'h0, 32'h0,      1'b1, 32'h55667788, 16'd1};
        vecs[4] = '{1'b1, 10'h010, 4'h0, 32'h0,      1'b1, 10'h020, 4'h0, 32'h0BADF00D,
                    1'b0, 1'b1, 10'h020, 4'h0, 32'h0BADF00D, 1'b1, 32'h55667788, 16'd2};
        vecs[5] = '{1'b1, 10'h020, 4'hF, 32'hCAFEF00D, 1'b0, 10'h000, 4'h0, 32'h0,
                    1'b1, 1'b0, 10'h020, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 16'd2};
        vecs[6] = '{1'b0, 10'h000, 4'h0, 32'h0,      1'b1, 10'h020, 4'h0, 32'h0,
                    1'b0, 1'b1, 10'h020, 4'h0, 32'h0,      1'b1, 32'hCAFEF00D, 16'd2};
        vecs[7] = '{1'b1, 10'h010, 4'b0001, 32'h000000EE, 1'b1, 10'h3FF, 4'h0, 32'h0,
                    1'b1, 1'b0, 10'h010, 4'b0001, 32'h000000EE, 1'b0, 32'h0, 16'd3};
        vecs[8] = '{1'b1, 10'h010, 4'h0, 32'h0,      1'b0, 10'h000, 4'h0, 32'h0,
                    1'b1, 1'b0, 10'h010, 4'h0, 32'h0,      1'b1, 32'hDEADBEEE, 16'd3};
        vecs[9] = '{1'b1, 10'h020, 4'h0, 32'h0,      1'b1, 10'h3FF, 4'h0, 32'h0,
                    1'b0, 1'b1, 10'h3FF, 4'h0, 32'h0,      1'b1, 32'hAA22CCDD, 16'd4};

        clearInputs();
        rst = 1'b1;
        loadMem = 1'b1;
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset conflict_cnt", 32'(conflict_cnt), 32'd0);
        checkOutput("reset acks", {r0_ack, r1_ack}, 32'd0);
        checkOutput("reset ram_wea", 32'(ram_wea), 32'd0);
        checkOutput("reset ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("reset ram_dina", ram_dina, 32'd0);
        checkOutput("reset r0_rdata", r0_rdata, 32'd0);
        checkOutput("reset r1_rdata", r1_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        loadMem = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], i);
        end

        // A req that rises during ACCESS waits for the next IDLE and is
        // then served on its own.
        r0_req = 1'b1; r0_addr = 10'h010;
        @(posedge clk);
        @(negedge clk);
        r0_req = 1'b0; r1_req = 1'b1; r1_addr = 10'h3FF;
        @(negedge clk);
        checkOutput("late r0_ack", 32'(r0_ack), 32'd1);
        checkOutput("late r1_ack early", 32'(r1_ack), 32'd0);
        checkOutput("late r0_rdata", r0_rdata, 32'hDEADBEEE);
        @(negedge clk);
        checkOutput("late idle busy", 32'(busy), 32'd0);
        @(negedge clk);
        r1_req = 1'b0;
        @(negedge clk);
        checkOutput("late r1_ack", 32'(r1_ack), 32'd1);
        checkOutput("late r1_rdata", r1_rdata, 32'hAA22CCDD);
        checkOutput("late conflict_cnt", 32'(conflict_cnt), 32'd4);
        @(negedge clk);
        clearInputs();

        // Sustained contention from reset: grants alternate starting with r0,
        // one ack every 3 cycles, every arbitration is a conflict.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        r0_req = 1'b1; r0_addr = 10'h010;
        r1_req = 1'b1; r1_addr = 10'h3FF;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("contend r0_ack k=%0d", k), 32'(r0_ack),
                        32'((k % 3 == 1) && ((k / 3) % 2 == 0)));
            checkOutput($sformatf("contend r1_ack k=%0d", k), 32'(r1_ack),
                        32'((k % 3 == 1) && ((k / 3) % 2 == 1)));
            checkOutput($sformatf("contend busy k=%0d", k), 32'(busy), 32'(k % 3 != 2));
            if (k == 1) checkOutput("contend r0_rdata", r0_rdata, 32'hDEADBEEE);
            if (k == 4) checkOutput("contend r1_rdata", r1_rdata, 32'hAA22CCDD);
        end
        clearInputs();
        checkOutput("contend conflict_cnt", 32'(conflict_cnt), 32'd10);

        // Reset during a write's ACCESS: the write never reaches the RAM,
        // no ack follows, and the counter is cleared.
        @(negedge clk);
        r1_req = 1'b1; r1_addr = 10'h010; r1_we = 4'hF; r1_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        checkOutput("abort wea before", 32'(ram_wea), 32'hF);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort wea", 32'(ram_wea), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort conflict_cnt", 32'(conflict_cnt), 32'd0);
        @(negedge clk);
        clearInputs();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("abort no ack k=%0d", k), {r0_ack, r1_ack, busy}, 32'd0);
        end
        v = '{1'b1, 10'h010, 4'h0, 32'h0, 1'b0, 10'h000, 4'h0, 32'h0,
              1'b1, 1'b0, 10'h010, 4'h0, 32'h0, 1'b1, 32'hDEADBEEE, 16'd0};
        applyStimulus(v, 100);

        // Saturation: preset the counter just below its maximum, then keep
        // both requesters busy for three conflicts.
        force dut.conflictCnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.conflictCnt_q;
        @(negedge clk);
        checkOutput("sat preset", 32'(conflict_cnt), 32'hFFFE);
        r0_req = 1'b1; r1_req = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) checkOutput("sat after 2", 32'(conflict_cnt), 32'hFFFF);
            if (k == 6) checkOutput("sat after 3", 32'(conflict_cnt), 32'hFFFF);
        end
        clearInputs();
        @(negedge clk);
        checkOutput("sat hold", 32'(conflict_cnt), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
